// File: rtl/seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_ctrl
//
// Time-multiplexed scan controller for NUM_DIGITS common-anode seven-segment
// digits sharing one external 4-bit-to-7-segment decoder. Each digit slot is
// a blanking guard interval (GUARD_CYCLES) followed by a lit interval
// (REFRESH_DIV). New display values are double-buffered: a load strobe fills
// a pending buffer, which is copied into the active buffer only at a frame
// boundary, so a frame never shows a mix of old and new digits.
//
// Optional feature (compile-time macro LEADING_ZERO_BLANK_EN):
//   When defined, digits above digit 0 whose nibble and every higher nibble
//   of the active value are zero are blanked. Digit 0 is always eligible.
//   When undefined, digits are shown according to digit_en only.
//
// Parameters:
//   NUM_DIGITS   - number of multiplexed digits (2..8)
//   REFRESH_DIV  - cycles each digit is lit per slot (>=2)
//   GUARD_CYCLES - blanking cycles before each digit is lit (>=1)
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   value      - display value, nibble i drives digit i (digit 0 rightmost)
//   digit_en   - per-digit enable mask, sampled at the start of each lit slot
//   load       - one-cycle strobe capturing value into the pending buffer
//   load_ack   - one-cycle pulse when the pending value becomes active
//   dec_val    - nibble to the decoder (bit 3 = Z ... bit 0 = W)
//   dec_en     - decoder enable, 0 blanks all segments
//   anode_n    - active-low digit select, at most one bit low
//   frame_done - one-cycle pulse after the last digit's slot ends
// ---------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic                    load_ack,
    output logic [3:0]              dec_val,
    output logic                    dec_en,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic                    frame_done
);

    localparam int DATA_W  = 4 * NUM_DIGITS;
    localparam int MAX_CNT = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ALL_OFF = {NUM_DIGITS{1'b1}};

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   slot_cnt;
    logic [IDX_W-1:0]   idx;
    logic [DATA_W-1:0]  active_buf;
    logic [DATA_W-1:0]  pend_buf;
    logic               pend_valid;

    logic [3:0]         cur_nib;
    logic               upper_zero;
    logic               digit_visible;
    logic               guard_end;
    logic               show_end;
    logic               commit;

    // Select the nibble of the current digit from the active buffer, and
    // work out whether this digit and every digit above it are zero. The
    // loops use constant slice positions so the mux stays simple.
    always_comb begin
        cur_nib    = 4'h0;
        upper_zero = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib    = active_buf[4*i +: 4];
                upper_zero = ((active_buf >> (4*i)) == '0);
            end
        end
    end

    // Decide whether the digit about to be lit is actually driven. A
    // disabled digit still consumes its full slot so every lit digit keeps
    // the same duty cycle and therefore the same brightness.
    always_comb begin
        digit_visible = digit_en[idx];
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx != '0) && upper_zero) begin
            digit_visible = 1'b0;
        end
`endif
    end

    // Slot boundary decodes. The frame boundary is the final lit cycle of
    // the last digit; the commit becomes visible on the following cycle.
    always_comb begin
        guard_end = (state == BLANK) && (slot_cnt == GUARD_LAST);
        show_end  = (state == SHOW)  && (slot_cnt == SHOW_LAST);
        commit    = show_end && (idx == LAST_IDX);
    end

    // Scan FSM, double buffer and all registered outputs. Outputs are
    // loaded on the same edge as the state change they belong to, so the
    // pins always match the state being displayed. digit_en and the
    // leading-zero decision are therefore sampled only on SHOW entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BLANK;
            slot_cnt   <= '0;
            idx        <= '0;
            active_buf <= '0;
            pend_buf   <= '0;
            pend_valid <= 1'b0;
            dec_val    <= 4'h0;
            dec_en     <= 1'b0;
            anode_n    <= ALL_OFF;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            load_ack   <= 1'b0;
            frame_done <= 1'b0;

            case (state)
                BLANK: begin
                    if (guard_end) begin
                        state    <= SHOW;
                        slot_cnt <= '0;
                        dec_val  <= cur_nib;
                        if (digit_visible) begin
                            dec_en  <= 1'b1;
                            anode_n <= ~(NUM_DIGITS'(1) << idx);
                        end else begin
                            dec_en  <= 1'b0;
                            anode_n <= ALL_OFF;
                        end
                    end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                    end
                end

                SHOW: begin
                    if (show_end) begin
                        state    <= BLANK;
                        slot_cnt <= '0;
                        dec_en   <= 1'b0;
                        anode_n  <= ALL_OFF;
                        if (idx == LAST_IDX) begin
                            idx <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                        if (commit) begin
                            frame_done <= 1'b1;
                            if (pend_valid) begin
                                active_buf <= pend_buf;
                                load_ack   <= 1'b1;
                            end
                        end
                    end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                    end
                end

                default: begin
                    state    <= BLANK;
                    slot_cnt <= '0;
                    dec_en   <= 1'b0;
                    anode_n  <= ALL_OFF;
                end
            endcase

            // A load always lands in the pending buffer, even on the commit
            // edge: the old pending value moves to active while the new one
            // waits for the next frame boundary. Repeated loads overwrite.
            if (load) begin
                pend_buf   <= value;
                pend_valid <= 1'b1;
            end else if (commit) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule
